gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter.sv | 64 ++++++
 tb/tb_gray_counter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray copy and wrap pulse; load/clear/step visible 1 cycle later.
// No backpressure: every enabled cycle advances exactly one step.
module gray_counter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [N-1:0] d_i,
  input  logic         down_i,
  output logic [N-1:0] q_o,
  output logic [N-1:0] gray_o,
  output logic         wrap_o
);

  if (N < 1 || N > 32) begin : g_bad_width
    $error("gray_counter: N must be in 1..32");
  end

  localparam logic [N-1:0] ALL_ONES = '1;

  logic [N-1:0] b_q, b_d;
  logic [N-1:0] g_q, g_d;
  logic         wrap_q, wrap_d;

  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    if (clear_i) begin
      b_d = '0;
    end else if (load_i) begin
      b_d = d_i;
    end else if (en_i) begin
      if (down_i) begin
        b_d    = b_q - 1'b1;
        wrap_d = (b_q == '0);
      end else begin
        b_d    = b_q + 1'b1;
        wrap_d = (b_q == ALL_ONES);
      end
    end
    // Gray is encoded from the next binary value so gray_o comes straight off flops.
    g_d = b_d ^ (b_d >> 1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_q    <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end

  assign q_o    = b_q;
  assign gray_o = g_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: integer model checked every cycle, plus literal pins for the key scenarios.
module tb_gray_counter;

  logic       clk;
  logic       rst_n;
  logic       clr, ld, en, dn;
  logic [3:0] d;
  logic [3:0] q, g;
  logic       w;
  logic [0:0] q1, g1;
  logic       w1;

  int checks = 0;
  int errors = 0;

  int m_q  = 0;
  int m1_q = 0;
  bit m_w  = 1'b0;
  bit m1_w = 1'b0;
  bit m_step = 1'b0;

  gray_counter #(.N(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .en_i(en), .load_i(ld),
    .d_i(d), .down_i(dn), .q_o(q), .gray_o(g), .wrap_o(w)
  );

  gray_counter #(.N(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .en_i(en), .load_i(ld),
    .d_i(d[0:0]), .down_i(dn), .q_o(q1), .gray_o(g1), .wrap_o(w1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  function automatic int g2b(input logic [3:0] gv);
    logic [3:0] r;
    r[3] = gv[3];
    for (int i = 2; i >= 0; i--) r[i] = r[i+1] ^ gv[i];
    return int'(r);
  endfunction

  function automatic int nxt_val(input int v, input int max);
    if (clr) return 0;
    if (ld) return int'(d) % max;
    if (en) return dn ? (v + max - 1) % max : (v + 1) % max;
    return v;
  endfunction

  function automatic bit nxt_wrap(input int v, input int max);
    if (clr || ld || !en) return 1'b0;
    return dn ? (v == 0) : (v == max - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= 0;
      m_w    <= 1'b0;
      m1_q   <= 0;
      m1_w   <= 1'b0;
      m_step <= 1'b0;
    end else begin
      m_q    <= nxt_val(m_q, 16);
      m_w    <= nxt_wrap(m_q, 16);
      m1_q   <= nxt_val(m1_q, 2);
      m1_w   <= nxt_wrap(m1_q, 2);
      m_step <= en && !clr && !ld;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    logic [3:0] prev_g;
    prev_g = '0;
    forever begin
      @(negedge clk);
      chk("q", int'(q), m_q);
      chk("gray", int'(g), gray_of(m_q));
      chk("wrap", int'(w), int'(m_w));
      chk("gray_to_bin", g2b(g), m_q);
      if (m_step) chk("hamming", $countones(g ^ prev_g), 1);
      chk("q_n1", int'(q1), m1_q);
      chk("gray_n1", int'(g1), m1_q);
      chk("wrap_n1", int'(w1), int'(m1_w));
      prev_g = g;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] dv,
                       input logic e, input logic down);
    clr = c; ld = l; d = dv; en = e; dn = down;
  endtask

  task automatic pin(input string nm, input int eq, input int eg, input int ew);
    chk({nm, "_q"}, int'(q), eq);
    chk({nm, "_gray"}, int'(g), eg);
    chk({nm, "_wrap"}, int'(w), ew);
  endtask

  initial begin
    int gtab [16];
    gtab = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    rst_n = 1'b1;
    drive(0, 0, 4'd0, 0, 0);
    #1 rst_n = 1'b0;
    #2 pin("reset", 0, 0, 0);

    // Release mid-cycle with en high: first edge after release must step from 0.
    @(posedge clk);
    #1;
    drive(0, 0, 4'd0, 1, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      pin("up_seq", k % 16, gtab[k % 16], (k == 16) ? 1 : 0);
    end

    drive(0, 0, 4'd0, 1, 1);
    tick();
    pin("down_wrap", 15, 4'b1000, 1);
    drive(0, 0, 4'd0, 0, 0);
    tick();
    pin("hold", 15, 4'b1000, 0);

    drive(0, 1, 4'd9, 1, 0);
    tick();
    pin("load9", 9, 4'b1101, 0);
    drive(0, 0, 4'd0, 1, 0);
    tick();
    pin("after_load", 10, 4'b1111, 0);
    tick();
    pin("up_again", 11, 4'b1110, 0);
    drive(0, 0, 4'd0, 1, 1);
    tick();
    pin("dir_change", 10, 4'b1111, 0);

    drive(0, 1, 4'd7, 0, 0);
    tick();
    pin("load7", 7, 4'b0100, 0);
    drive(1, 1, 4'd3, 1, 0);
    tick();
    pin("clear_over_load", 0, 0, 0);

    drive(0, 0, 4'd0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      en = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
      tick();
    end

    // Reset mid-cycle at count 15 with a wrap step pending on the next edge.
    drive(0, 1, 4'd15, 0, 0);
    tick();
    drive(0, 0, 4'd0, 1, 0);
    #2 rst_n = 1'b0;
    #1 pin("rst_pending_wrap", 0, 0, 0);
    tick();
    tick();
    drive(0, 0, 4'd0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
    pin("after_release1", 0, 0, 0);

    // Reset landing inside an active wrap pulse.
    drive(0, 1, 4'd15, 0, 0);
    tick();
    drive(0, 0, 4'd0, 1, 0);
    tick();
    pin("wrap_pulse", 0, 0, 1);
    #2 rst_n = 1'b0;
    #1 pin("rst_in_pulse", 0, 0, 0);
    drive(0, 0, 4'd0, 0, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    pin("after_release2", 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
